// File: rtl/rob_retire_pkg.sv
// rob_retire_pkg: shared sizes and the reorder-buffer entry layout for the commit side.
package rob_retire_pkg;
   localparam int ROB_DEPTH = 16;
   localparam int AREG_W    = 5;
   localparam int PREG_W    = 6;
   localparam int IDX_W     = $clog2(ROB_DEPTH);
   typedef struct packed {
      logic              valid;
      logic              done;
      logic [AREG_W-1:0] rd;
      logic [PREG_W-1:0] pd;
      logic [PREG_W-1:0] old_pd;
   } rob_entry_t;
endpackage

// File: rtl/rob_retire.sv
// rob_retire: 2-wide in-order reorder buffer that retires completed instrs and returns old pregs.
module rob_retire
   import rob_retire_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_valid_1,
   input  logic              disp_valid_2,
   input  logic [AREG_W-1:0] disp_rd_1,
   input  logic [AREG_W-1:0] disp_rd_2,
   input  logic [PREG_W-1:0] disp_pd_1,
   input  logic [PREG_W-1:0] disp_pd_2,
   input  logic [PREG_W-1:0] disp_old_pd_1,
   input  logic [PREG_W-1:0] disp_old_pd_2,
   output logic              disp_ready,
   output logic [IDX_W-1:0]  disp_idx_1,
   output logic [IDX_W-1:0]  disp_idx_2,
   input  logic              cmpl_valid_1,
   input  logic              cmpl_valid_2,
   input  logic [IDX_W-1:0]  cmpl_idx_1,
   input  logic [IDX_W-1:0]  cmpl_idx_2,
   output logic              ret_valid_1,
   output logic              ret_valid_2,
   output logic [AREG_W-1:0] ret_rd_1,
   output logic [AREG_W-1:0] ret_rd_2,
   output logic [PREG_W-1:0] ret_pd_1,
   output logic [PREG_W-1:0] ret_pd_2,
   output logic              free_valid_1,
   output logic              free_valid_2,
   output logic [PREG_W-1:0] free_p_1,
   output logic [PREG_W-1:0] free_p_2,
   output logic [IDX_W:0]    rob_count,
   output logic              rob_empty,
   output logic              rob_full
);
   localparam int CW = IDX_W + 1;
   rob_entry_t       rob [ROB_DEPTH];
   logic [IDX_W-1:0] head, tail, head_2;
   logic [CW-1:0]    count;
   logic             acc_1, acc_2, r_1, r_2, f_1, f_2;
   assign disp_ready = count <= CW'(ROB_DEPTH - 2);
   assign disp_idx_1 = tail;
   assign disp_idx_2 = tail + IDX_W'(1);
   assign head_2     = head + IDX_W'(1);
   assign acc_1      = disp_valid_1 && disp_ready;
   assign acc_2      = acc_1 && disp_valid_2;
   assign r_1        = rob[head].valid && rob[head].done;
   assign r_2        = r_1 && rob[head_2].valid && rob[head_2].done;
   assign f_1        = r_1 && rob[head].rd != '0;
   assign f_2        = r_2 && rob[head_2].rd != '0;
   assign rob_count  = count;
   assign rob_empty  = count == '0;
   assign rob_full   = count == CW'(ROB_DEPTH);
   // Dispatch slots are always free entries, so they never collide with the retiring head pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
         ret_valid_1  <= 1'b0;
         ret_valid_2  <= 1'b0;
         ret_rd_1     <= '0;
         ret_rd_2     <= '0;
         ret_pd_1     <= '0;
         ret_pd_2     <= '0;
         free_valid_1 <= 1'b0;
         free_valid_2 <= 1'b0;
         free_p_1     <= '0;
         free_p_2     <= '0;
      end else begin
         if (acc_1) rob[disp_idx_1] <= '{valid: 1'b1, done: 1'b0, rd: disp_rd_1, pd: disp_pd_1, old_pd: disp_old_pd_1};
         if (acc_2) rob[disp_idx_2] <= '{valid: 1'b1, done: 1'b0, rd: disp_rd_2, pd: disp_pd_2, old_pd: disp_old_pd_2};
         if (cmpl_valid_1 && rob[cmpl_idx_1].valid) rob[cmpl_idx_1].done <= 1'b1;
         if (cmpl_valid_2 && rob[cmpl_idx_2].valid) rob[cmpl_idx_2].done <= 1'b1;
         if (r_1) rob[head].valid <= 1'b0;
         if (r_2) rob[head_2].valid <= 1'b0;
         ret_valid_1  <= r_1;
         ret_valid_2  <= r_2;
         ret_rd_1     <= r_1 ? rob[head].rd : '0;
         ret_rd_2     <= r_2 ? rob[head_2].rd : '0;
         ret_pd_1     <= r_1 ? rob[head].pd : '0;
         ret_pd_2     <= r_2 ? rob[head_2].pd : '0;
         free_valid_1 <= f_1;
         free_valid_2 <= f_2;
         free_p_1     <= f_1 ? rob[head].old_pd : '0;
         free_p_2     <= f_2 ? rob[head_2].old_pd : '0;
         head         <= head + IDX_W'(r_1) + IDX_W'(r_2);
         tail         <= tail + IDX_W'(acc_1) + IDX_W'(acc_2);
         count        <= count + CW'(acc_1) + CW'(acc_2) - CW'(r_1) - CW'(r_2);
      end
   end
endmodule
